// File: rtl/ddc_cfg_pkg.sv
// Shared definitions for the DDC configuration loader: target codes,
// loader state encoding, pass-flag bit positions and a target decoder.
package ddc_cfg_pkg;

    localparam logic [3:0] TGT_NCO       = 4'd0;
    localparam logic [3:0] TGT_NCOGAIN   = 4'd1;
    localparam logic [3:0] TGT_HB        = 4'd2;
    localparam logic [3:0] TGT_CIC       = 4'd3;
    localparam logic [3:0] TGT_DECIMGAIN = 4'd4;
    localparam logic [3:0] TGT_HBGAIN    = 4'd5;
    localparam logic [3:0] TGT_FIR       = 4'd6;
    localparam logic [3:0] TGT_FIRGAIN   = 4'd7;
    localparam logic [3:0] TGT_PASS      = 4'd8;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        GAP,
        FLUSH,
        SYNC
    } cfg_state_e;

    localparam int PASS_NCO = 0;
    localparam int PASS_CIC = 1;
    localparam int PASS_HB  = 2;
    localparam int PASS_FIR = 3;

    // One-hot stage strobe for a target; pass-flag and invalid targets strobe nothing.
    function automatic logic [7:0] tgt_onehot(input logic [3:0] tgt);
        logic [7:0] oh;
        oh = '0;
        case (tgt)
            TGT_NCO:       oh[0] = 1'b1;
            TGT_NCOGAIN:   oh[1] = 1'b1;
            TGT_HB:        oh[2] = 1'b1;
            TGT_CIC:       oh[3] = 1'b1;
            TGT_DECIMGAIN: oh[4] = 1'b1;
            TGT_HBGAIN:    oh[5] = 1'b1;
            TGT_FIR:       oh[6] = 1'b1;
            TGT_FIRGAIN:   oh[7] = 1'b1;
            default:       oh    = '0;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/ddc_cfg_holdreg.sv
// One-entry holding register for the word that arrives with a new target;
// it is parked here while the loader spends one idle cycle between bursts.
module ddc_cfg_holdreg #(
    parameter int COEBITWIDTH = 16
) (
    input  logic                   clk,
    input  logic                   load_i,
    input  logic [COEBITWIDTH-1:0] word_i,
    input  logic                   last_i,
    output logic [COEBITWIDTH-1:0] word_o,
    output logic                   last_o
);

    logic [COEBITWIDTH-1:0] word_q;
    logic                   last_q;

    // Capture the parked word and its end-of-session marker.
    always_ff @(posedge clk) begin
        if (load_i) begin
            word_q <= word_i;
            last_q <= last_i;
        end
    end

    assign word_o = word_q;
    assign last_o = last_q;

endmodule

// File: rtl/ddc_cfg_loader.sv
// Host-side configuration master for the DDC chain. Replays host words as a
// per-stage indicator strobe plus shared param word, separates target bursts
// by one idle cycle, and closes each session with a config_sync pulse.
module ddc_cfg_loader
    import ddc_cfg_pkg::*;
#(
    parameter int COEBITWIDTH = 16,
    parameter int MAXWORDS    = 64,
    parameter int SYNC_GAP    = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic [3:0]             cfg_target,
    input  logic [COEBITWIDTH-1:0] cfg_data,
    input  logic                   cfg_last,
    input  logic                   err_clr,
    output logic [7:0]             stage_indicator,
    output logic [COEBITWIDTH-1:0] cfg_param,
    output logic                   config_sync,
    output logic [3:0]             pass_flags,
    output logic                   busy,
    output logic [1:0]             err
);

    localparam int              CNT_W   = $clog2(MAXWORDS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAXWORDS);

    cfg_state_e             state_q;
    logic [3:0]             burst_tgt_q;
    logic [CNT_W-1:0]       word_cnt_q;
    logic [7:0]             flush_cnt_q;
    logic [7:0]             stage_indicator_q;
    logic [COEBITWIDTH-1:0] cfg_param_q;
    logic                   config_sync_q;
    logic [3:0]             pass_flags_q;
    logic                   busy_q;
    logic [1:0]             err_q;

    logic                   xfer;
    logic                   same_tgt;
    logic                   hold_load;
    logic [COEBITWIDTH-1:0] hold_word;
    logic                   hold_last;
    logic                   emit_v;
    logic [3:0]             emit_tgt;
    logic [COEBITWIDTH-1:0] emit_word;
    logic [CNT_W-1:0]       emit_base;
    logic                   drop_over;
    logic                   bad_tgt;
    logic                   keep;

    assign cfg_ready = (state_q == IDLE) || (state_q == LOAD);
    assign xfer      = cfg_valid && cfg_ready;
    assign same_tgt  = (cfg_target == burst_tgt_q);

    ddc_cfg_holdreg #(
        .COEBITWIDTH (COEBITWIDTH)
    ) u_holdreg (
        .clk    (clk),
        .load_i (hold_load),
        .word_i (cfg_data),
        .last_i (cfg_last),
        .word_o (hold_word),
        .last_o (hold_last)
    );

    // Decide which word (if any) is emitted next cycle and whether it is kept or dropped.
    always_comb begin
        emit_v    = 1'b0;
        emit_tgt  = cfg_target;
        emit_word = cfg_data;
        emit_base = '0;
        hold_load = 1'b0;
        case (state_q)
            IDLE: emit_v = xfer;
            LOAD: begin
                if (xfer) begin
                    if (same_tgt) begin
                        emit_v    = 1'b1;
                        emit_base = word_cnt_q;
                    end else begin
                        hold_load = 1'b1;
                    end
                end
            end
            GAP: begin
                emit_v    = 1'b1;
                emit_tgt  = burst_tgt_q;
                emit_word = hold_word;
            end
            default: emit_v = 1'b0;
        endcase
        drop_over = emit_v && (emit_base == CNT_MAX);
        bad_tgt   = emit_v && (emit_tgt > TGT_PASS);
        keep      = emit_v && !drop_over && !bad_tgt;
    end

    // Session FSM together with every registered output.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q           <= IDLE;
            burst_tgt_q       <= '0;
            word_cnt_q        <= '0;
            flush_cnt_q       <= '0;
            stage_indicator_q <= '0;
            cfg_param_q       <= '0;
            config_sync_q     <= 1'b0;
            pass_flags_q      <= '0;
            busy_q            <= 1'b0;
            err_q             <= '0;
        end else begin
            stage_indicator_q <= keep ? tgt_onehot(emit_tgt) : 8'd0;
            if (keep) begin
                cfg_param_q <= emit_word;
            end
            if (keep && (emit_tgt == TGT_PASS)) begin
                pass_flags_q[PASS_NCO] <= emit_word[PASS_NCO];
                pass_flags_q[PASS_CIC] <= emit_word[PASS_CIC];
                pass_flags_q[PASS_HB]  <= emit_word[PASS_HB];
                pass_flags_q[PASS_FIR] <= emit_word[PASS_FIR];
            end
            if (emit_v) begin
                word_cnt_q <= drop_over ? emit_base : emit_base + 1'b1;
            end
            // A new error in the same cycle as err_clr keeps its bit set.
            err_q         <= (err_q & ~{2{err_clr}}) | {drop_over, bad_tgt};
            config_sync_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (xfer) begin
                        burst_tgt_q <= cfg_target;
                        flush_cnt_q <= '0;
                        busy_q      <= 1'b1;
                        state_q     <= cfg_last ? FLUSH : LOAD;
                    end
                end
                LOAD: begin
                    if (xfer) begin
                        if (!same_tgt) begin
                            burst_tgt_q <= cfg_target;
                            state_q     <= GAP;
                        end else if (cfg_last) begin
                            flush_cnt_q <= '0;
                            state_q     <= FLUSH;
                        end
                    end
                end
                GAP: begin
                    flush_cnt_q <= '0;
                    state_q     <= hold_last ? FLUSH : LOAD;
                end
                // First FLUSH cycle carries the final emit; SYNC_GAP quiet cycles follow.
                FLUSH: begin
                    if (flush_cnt_q == 8'(SYNC_GAP)) begin
                        config_sync_q <= 1'b1;
                        state_q       <= SYNC;
                    end else begin
                        flush_cnt_q <= flush_cnt_q + 8'd1;
                    end
                end
                SYNC: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign stage_indicator = stage_indicator_q;
    assign cfg_param       = cfg_param_q;
    assign config_sync     = config_sync_q;
    assign pass_flags      = pass_flags_q;
    assign busy            = busy_q;
    assign err             = err_q;

endmodule

// File: tb/tb_ddc_cfg_loader.sv
// Scoreboard bench for ddc_cfg_loader: the driver feeds a reference model
// that queues expected indicator and config_sync events with their cycle;
// a negedge monitor pops and compares whenever the DUT presents one.
module tb_ddc_cfg_loader;

    localparam int W        = 16;
    localparam int MAXWORDS = 64;
    localparam int SYNC_GAP = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cfg_valid = 1'b0;
    logic         cfg_ready;
    logic [3:0]   cfg_target = '0;
    logic [W-1:0] cfg_data = '0;
    logic         cfg_last = 1'b0;
    logic         err_clr = 1'b0;
    logic [7:0]   stage_indicator;
    logic [W-1:0] cfg_param;
    logic         config_sync;
    logic [3:0]   pass_flags;
    logic         busy;
    logic [1:0]   err;

    ddc_cfg_loader #(
        .COEBITWIDTH (W),
        .MAXWORDS    (MAXWORDS),
        .SYNC_GAP    (SYNC_GAP)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .cfg_valid       (cfg_valid),
        .cfg_ready       (cfg_ready),
        .cfg_target      (cfg_target),
        .cfg_data        (cfg_data),
        .cfg_last        (cfg_last),
        .err_clr         (err_clr),
        .stage_indicator (stage_indicator),
        .cfg_param       (cfg_param),
        .config_sync     (config_sync),
        .pass_flags      (pass_flags),
        .busy            (busy),
        .err             (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int           cyc;
        logic [7:0]   ind;
        logic [W-1:0] param;
    } ind_ev_t;

    ind_ev_t ind_q[$];
    int      sync_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state: a session is a sequence of per-target bursts
    int         m_tgt = -1;
    int         m_cnt = 0;
    logic [1:0] exp_err = '0;
    logic [3:0] exp_pass = '0;
    logic [W-1:0] exp_param = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // word accepted while presented in cycle a
    task automatic model_accept(input logic [3:0] t, input logic [W-1:0] d, input logic l, input int a);
        int ecyc;
        if (m_tgt < 0 || m_tgt == int'(t)) ecyc = a + 1;
        else ecyc = a + 2;
        if (m_tgt != int'(t)) m_cnt = 0;
        m_tgt = int'(t);
        m_cnt++;
        if (m_cnt > MAXWORDS) exp_err[1] = 1'b1;
        if (t > 4'd8) exp_err[0] = 1'b1;
        if (m_cnt <= MAXWORDS && t <= 4'd8) begin
            exp_param = d;
            if (t == 4'd8) exp_pass = d[3:0];
            else ind_q.push_back('{ecyc, 8'(1 << t), d});
        end
        if (l) begin
            sync_q.push_back(ecyc + 1 + SYNC_GAP);
            m_tgt = -1;
        end
    endtask

    // Monitor: compare each presented strobe against the head of its queue.
    always @(negedge clk) begin
        ind_ev_t e;
        int      s;
        if (stage_indicator != 8'd0) begin
            if (ind_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL unexpected_indicator: got 0x%0h, expected none (cycle %0d)", stage_indicator, cyc);
            end else begin
                e = ind_q.pop_front();
                chk("ind_cycle", cyc, e.cyc);
                chk("ind_bits", {24'd0, stage_indicator}, {24'd0, e.ind});
                chk("ind_param", {16'd0, cfg_param}, {16'd0, e.param});
            end
        end
        if (config_sync == 1'b1) begin
            if (sync_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL unexpected_sync: got pulse, expected none (cycle %0d)", cyc);
            end else begin
                s = sync_q.pop_front();
                chk("sync_cycle", cyc, s);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present one word and hold it until accepted; returns 1 time unit after the accepting edge.
    task automatic send(input logic [3:0] t, input logic [W-1:0] d, input logic l);
        int waitc;
        cfg_valid  = 1'b1;
        cfg_target = t;
        cfg_data   = d;
        cfg_last   = l;
        waitc      = 0;
        @(negedge clk);
        while (!cfg_ready) begin
            waitc++;
            if (waitc > 50) begin
                n_cmp++; n_bad++;
                $display("FAIL ready_timeout: got ready=0 for %0d cycles, expected acceptance", waitc);
                cfg_valid = 1'b0;
                tick(1);
                return;
            end
            @(negedge clk);
        end
        model_accept(t, d, l, cyc);
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
        cfg_last  = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int t;
        t = 0;
        while ((ind_q.size() != 0 || sync_q.size() != 0) && t < 400) begin
            tick(1);
            t++;
        end
        chk({tag, "_drained"}, ind_q.size() + sync_q.size(), 0);
        tick(1);
        chk({tag, "_busy"}, {31'd0, busy}, 0);
        chk({tag, "_ready"}, {31'd0, cfg_ready}, 1);
        chk({tag, "_err"}, {30'd0, err}, {30'd0, exp_err});
        chk({tag, "_pass"}, {28'd0, pass_flags}, {28'd0, exp_pass});
        chk({tag, "_param"}, {16'd0, cfg_param}, {16'd0, exp_param});
    endtask

    task automatic clear_err();
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        exp_err = '0;
        chk("err_clear", {30'd0, err}, 0);
    endtask

    function automatic logic [3:0] pick_tgt();
        if ($urandom_range(0, 9) == 9) return 4'($urandom_range(9, 15));
        return 4'($urandom_range(0, 8));
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ind"}, {24'd0, stage_indicator}, 0);
        chk({tag, "_param"}, {16'd0, cfg_param}, 0);
        chk({tag, "_sync"}, {31'd0, config_sync}, 0);
        chk({tag, "_pass"}, {28'd0, pass_flags}, 0);
        chk({tag, "_busy"}, {31'd0, busy}, 0);
        chk({tag, "_err"}, {30'd0, err}, 0);
        chk({tag, "_ready"}, {31'd0, cfg_ready}, 1);
    endtask

    initial begin
        int         nw;
        logic [3:0] t;
        tick(3);
        check_reset_outputs("reset");
        rst = 1'b0;
        tick(1);

        // 1: three nco words, last on the third
        send(4'd0, 16'h0001, 1'b0);
        chk("t1_busy", {31'd0, busy}, 1);
        send(4'd0, 16'h0002, 1'b0);
        send(4'd0, 16'h0003, 1'b1);
        wait_idle("t1");

        // 2: fir then hb back-to-back, one-cycle ready gap
        send(4'd6, 16'hA5A5, 1'b0);
        send(4'd2, 16'h1234, 1'b0);
        chk("t2_ready_gap", {31'd0, cfg_ready}, 0);
        tick(1);
        chk("t2_ready_back", {31'd0, cfg_ready}, 1);
        send(4'd2, 16'h0055, 1'b1);
        wait_idle("t2");

        // 3: pass flags
        send(4'd8, 16'h000B, 1'b1);
        wait_idle("t3");

        // 4: bad target, then one fir word past the burst limit
        send(4'd12, 16'hDEAD, 1'b0);
        for (int i = 0; i < MAXWORDS + 1; i++) send(4'd6, 16'(i + 16'h0100), i == MAXWORDS);
        wait_idle("t4");
        clear_err();

        // 6: valid toggling every other cycle on one target
        for (int i = 0; i < 6; i++) begin
            send(4'd3, 16'($urandom), i == 5);
            tick(1);
        end
        wait_idle("t6");

        // random sessions
        for (int s = 0; s < 8; s++) begin
            nw = $urandom_range(1, 8);
            t  = pick_tgt();
            for (int w = 0; w < nw; w++) begin
                if ($urandom_range(0, 3) == 0) t = pick_tgt();
                send(t, 16'($urandom), w == nw - 1);
                tick($urandom_range(0, 2));
            end
            wait_idle("rnd");
            if (exp_err != 2'b00) clear_err();
        end

        // 5: reset during FLUSH aborts the pending config_sync
        send(4'd8, 16'h0005, 1'b1);
        wait_idle("t5_pre");
        send(4'd0, 16'h0077, 1'b1);
        rst = 1'b1;
        sync_q.delete();
        m_tgt     = -1;
        exp_err   = '0;
        exp_pass  = '0;
        exp_param = '0;
        tick(1);
        check_reset_outputs("t5_rst");
        rst = 1'b0;
        tick(1);
        chk("t5_ready_after", {31'd0, cfg_ready}, 1);
        tick(8);
        chk("t5_leftover", ind_q.size() + sync_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        n_bad++;
        $display("FAIL watchdog: got no completion, expected finish before 500000");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog expired");
    end

endmodule
